// File: rtl/det_pkg.sv
// det_pkg: shared widths, minor FSM states and result latency (MINOR2X2_FAST_MUL_EN selects the fast-multiply latency)
package det_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int OUT_W_DEF = 32;
  typedef enum logic [2:0] {IDLE, MUL_AD, MUL_BC, SUB, DONE} minor_state_t;
`ifdef MINOR2X2_FAST_MUL_EN
  localparam int LATENCY = 4;
`else
  localparam int LATENCY = 2 * DATA_W_DEF + 2;
`endif
endpackage

// File: rtl/minor2x2_unit_shift_add_mul.sv
// shift_add_mul: unsigned W x W radix-2 shift-add multiplier, one partial product per cycle, W cycles from start
module shift_add_mul #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  output logic             done,
  output logic [2*W-1:0]   product
);
  localparam int CW = $clog2(W);
  logic [2*W-1:0] acc, mc, cur_acc, cur_mc;
  logic [W-1:0] mp, cur_mp;
  logic [CW-1:0] cnt, cur_cnt;
  // start folds in the first step, so product/done show the final sum during the W-th cycle
  always_comb begin
    cur_acc = start ? '0 : acc;
    cur_mc = start ? {{W{1'b0}}, op_a} : mc;
    cur_mp = start ? op_b : mp;
    cur_cnt = start ? '0 : cnt;
    product = cur_acc + (cur_mp[0] ? cur_mc : '0);
    done = cur_cnt == CW'(W - 1);
  end
  // advance one multiplier bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      mc <= '0;
      mp <= '0;
      cnt <= '0;
    end else begin
      acc <= product;
      mc <= cur_mc << 1;
      mp <= cur_mp >> 1;
      cnt <= cur_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/minor2x2_unit.sv
// minor2x2_unit: sequential a*d - b*c engine with valid/ready on both sides; MINOR2X2_FAST_MUL_EN swaps in a one-cycle multiply
module minor2x2_unit
  import det_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);
  minor_state_t state, state_nxt;
  logic rdy_q, step_done;
  logic signed [DATA_W-1:0] ra, rb, rc, rd;
  logic [OUT_W-1:0] prod_ad, prod_bc, prod_val;
`ifdef MINOR2X2_FAST_MUL_EN
  // single-cycle signed product of the pair selected by the current state
  always_comb begin
    step_done = 1'b1;
    prod_val = (state == MUL_BC) ? OUT_W'(rb) * OUT_W'(rc) : OUT_W'(ra) * OUT_W'(rd);
  end
`else
  logic signed [DATA_W-1:0] op_x, op_y;
  logic [DATA_W-1:0] mag_x, mag_y;
  logic [2*DATA_W-1:0] mul_prod;
  logic neg, mul_done, start_q;
  // sign-magnitude split around the unsigned multiplier; -2^(W-1) maps to 2^(W-1) unchanged
  always_comb begin
    op_x = (state == MUL_BC) ? rb : ra;
    op_y = (state == MUL_BC) ? rc : rd;
    mag_x = op_x[DATA_W-1] ? -op_x : op_x;
    mag_y = op_y[DATA_W-1] ? -op_y : op_y;
    neg = op_x[DATA_W-1] ^ op_y[DATA_W-1];
    step_done = mul_done;
    prod_val = neg ? -mul_prod : mul_prod;
  end
  // pulse start on the first cycle of each multiply state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else start_q <= (state_nxt == MUL_AD || state_nxt == MUL_BC) && state_nxt != state;
  end
  shift_add_mul #(.W(DATA_W)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(start_q),
    .op_a(mag_x),
    .op_b(mag_y),
    .done(mul_done),
    .product(mul_prod)
  );
`endif
  // state register; rdy_q keeps in_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= 1'b1;
    end
  end
  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = (in_valid && in_ready) ? MUL_AD : IDLE;
      MUL_AD: state_nxt = step_done ? MUL_BC : MUL_AD;
      MUL_BC: state_nxt = step_done ? SUB : MUL_BC;
      SUB: state_nxt = DONE;
      DONE: state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    in_ready = rdy_q && state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  // operand capture, product storage and final subtraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      rc <= '0;
      rd <= '0;
      prod_ad <= '0;
      prod_bc <= '0;
      out_data <= '0;
    end else begin
      if (state == IDLE && in_valid && in_ready) begin
        ra <= a;
        rb <= b;
        rc <= c;
        rd <= d;
      end
      if (state == MUL_AD && step_done) prod_ad <= prod_val;
      if (state == MUL_BC && step_done) prod_bc <= prod_val;
      if (state == SUB) out_data <= prod_ad - prod_bc;
    end
  end
endmodule

// File: tb/tb_minor2x2_unit.sv
// tb_minor2x2_unit: directed and random checks of minor2x2_unit against an arithmetic a*d - b*c model
module tb_minor2x2_unit;
  import det_pkg::*;
  localparam int P = LATENCY + 1;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b, c, d;
  logic [31:0] out_data;
  int errs = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  minor2x2_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .c(c),
    .d(d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] ma, mb, mc, md);
    longint e;
    e = longint'($signed(ma)) * longint'($signed(md)) - longint'($signed(mb)) * longint'($signed(mc));
    return e[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] ta, tb, tc, td, input logic [31:0] exp, input int hold);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    a = ta; b = tb; c = tc; d = td;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k + 1, LATENCY);
    chk("out_data", out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_data", out_data, exp);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_pulse_end", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    logic [15:0] ra, rb, rc, rd;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; c = '0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("first_clk_in_ready", in_ready, 1);
    chk("first_clk_busy", busy, 0);

    run_op(16'd3, 16'd2, 16'd1, 16'd4, 32'h0000000A, 0);
    run_op(16'd1, 16'd5, 16'd7, 16'd2, 32'hFFFFFFDF, 0);
    run_op(16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 32'h7FFF8000, 0);
    run_op(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 32'h80008000, 0);
    run_op(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 32'h7FFE8001, 0);
    run_op(16'h8000, 16'h8000, 16'h8000, 16'h8000, 32'h00000000, 0);
    run_op(16'hFFFF, 16'd0, 16'd9, 16'hFFFF, 32'h00000001, 10);

    in_valid = 1'b1;
    a = 16'd100; b = 16'd3; c = 16'd7; d = 16'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_recover_ready", in_ready, 1);
    run_op(16'd2, 16'd0, 16'd0, 16'd2, 32'd4, 0);

    for (int n = 0; n < 12; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom); rd = 16'($urandom);
      run_op(ra, rb, rc, rd, model(ra, rb, rc, rd), int'($urandom_range(0, 3)));
    end

    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    for (int i = 0; i < 5 * P; i++) begin
      chk("b2b_in_ready", in_ready, (i % P) == 0);
      chk("b2b_out_valid", out_valid, (i % P) == LATENCY);
      if ((i % P) == 0) exp_q.push_back(model(a, b, c, d));
      if ((i % P) == LATENCY) begin
        if (exp_q.size() > 0) chk("b2b_data", out_data, exp_q.pop_front());
      end
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    end
    in_valid = 1'b0;
    chk("b2b_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/minor2x2_unit.md
# minor2x2_unit

Sequential 2x2 minor engine for the determinant datapath: accepts four signed entries a, b, c, d and produces the cofactor term a·d − b·c. It uses one shared iterative multiplier with valid/ready handshakes on both sides. It sits directly upstream of the 32-bit accumulation adder, and its out_data connects to one adder operand. Results are signed and OUT_W = 2·DATA_W wide, so the default configuration matches the adder's 32-bit operands.

## Interface
- DATA_W, 16, width of each signed input entry
- OUT_W, 2*DATA_W, width of the signed result; must equal the downstream adder width (32)
- clk  in  1  clock, all state on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand set valid
- in_ready  out  1  unit can accept an operand set
- a, b, c, d  in  DATA_W each  signed matrix entries (row 0: a b; row 1: c d)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  OUT_W  signed a·d − b·c
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, MUL_AD, MUL_BC, SUB, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register a, b, c, d and go to MUL_AD.
- MUL_AD / MUL_BC:
  - Form the unsigned magnitudes of the two operands, with the sign = XOR of the operand signs.
  - Run the radix-2 shift-add multiplier for exactly DATA_W cycles.
  - Negate the product if the sign is set.
  - Store the result in prod_ad or prod_bc.
  - Magnitude of −2^(DATA_W−1) is 2^(DATA_W−1), which fits in DATA_W unsigned bits and needs no special case.
- SUB: out_data ← prod_ad − prod_bc, computed in OUT_W-bit two's complement. Overflow cannot occur: worst case is 2^(2·DATA_W−1) − 2^(DATA_W−1).
- DONE: out_valid=1, out_data stable. On out_valid&&out_ready, go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Inputs a–d are ignored outside the accept cycle.
- in_valid may drop without being accepted; no state change results.

## Timing
- Reset values: in_ready=0 during reset and 1 from the first clock after release; out_valid=0; out_data=0; busy=0; FSM=IDLE; product registers 0.
- Accept edge = cycle 0:
  - MUL_AD occupies cycles 1..DATA_W.
  - MUL_BC occupies cycles DATA_W+1..2·DATA_W.
  - SUB occupies cycle 2·DATA_W+1.
  - out_valid rises at cycle 2·DATA_W+2 (34 for DATA_W=16).
- Throughput: one result per 2·DATA_W+3 cycles when out_ready is held high.
- Backpressure: out_data and out_valid hold indefinitely while out_ready=0.
- Reset asserted mid-operation: immediately return to IDLE and clear all outputs. The in-flight operand set is discarded.

## Configuration
- MINOR2X2_FAST_MUL_EN
  - Defined: each product is computed in one cycle by a combinational signed multiply. MUL_AD and MUL_BC last 1 cycle each, so out_valid rises at cycle 4 after accept.
  - Undefined: the iterative shift-add multiplier is used, with the latency given above.
  - Handshake, FSM state set and results are identical in both builds.

## Structure
- Shared package det_pkg holds:
  - DATA_W_DEF=16 and OUT_W_DEF=32 constants
  - the minor_state_t enum {IDLE, MUL_AD, MUL_BC, SUB, DONE}
  - the per-configuration latency constant, used by the bench
- One sub-module, shift_add_mul:
  - ports: start, op_a, op_b, done, product
  - performs unsigned DATA_W×DATA_W → 2·DATA_W shift-add multiplication
  - instanced once and reused for both products
  - not instantiated when MINOR2X2_FAST_MUL_EN is defined

## Test plan
- Basic: a=3, b=2, c=1, d=4, out_ready=1 → out_data=10 (0x0000000A), out_valid at cycle 34 (cycle 4 with MINOR2X2_FAST_MUL_EN), high for 1 cycle.
- Negative result: a=1, b=5, c=7, d=2 → out_data=−33 (0xFFFFFFDF).
- Extremes: a=d=b=−32768, c=32767 → out_data=2147450880 (0x7FFF8000), with no wrap.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises. out_data must stay stable, in_ready=0 and busy=1. After the handshake, in_ready=1 on the next cycle.
- Reset mid-op: assert rst_n=0 at cycle 12 after accept. All outputs go to their reset values at once. After release, a new set a=2, b=0, c=0, d=2 yields 4.
- Back-to-back: hold in_valid=1 continuously with out_ready=1. Results are spaced exactly 2·DATA_W+3 cycles apart, and in_ready is high only in IDLE.
